// File: rtl/ff_delay_pipe.sv
// Multi-stage delay pipeline: a WIDTH-bit payload and its valid bit travel through DEPTH
// register stages, with clock-enable stall, flush, occupancy count and optional valid-gated loads.
module ff_delay_pipe #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               GATE_DATA   = 1'b0,
  parameter bit               ASSERT_EN   = 1'b1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CE,
  input  logic                       FLUSH,
  input  logic [WIDTH-1:0]           I,
  input  logic                       I_valid,
  output logic [WIDTH-1:0]           O,
  output logic                       O_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH == 0) begin : g_depth_check
    $error("ff_delay_pipe: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [WIDTH-1:0] data_in [DEPTH];
  logic [DEPTH-1:0] valid_in;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             shift_en;

  assign shift_en = CE && !FLUSH;

  // Per-stage feed: stage 0 takes the input port, every later stage takes its predecessor.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign data_in[gi]  = I;
      assign valid_in[gi] = I_valid;
    end else begin : g_body
      assign data_in[gi]  = data_q[gi-1];
      assign valid_in[gi] = valid_q[gi-1];
    end

    always_comb begin
      data_d[gi] = data_q[gi];
      if (shift_en && (!GATE_DATA || valid_in[gi])) begin
        data_d[gi] = data_in[gi];
      end
    end

    // Flush leaves payload untouched; only reset reloads it.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        data_q[gi] <= RESET_VALUE;
      end else begin
        data_q[gi] <= data_d[gi];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    occ_d   = occ_q;
    if (FLUSH) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (CE) begin
      valid_d = valid_in;
      if (I_valid && !valid_q[DEPTH-1]) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (!I_valid && valid_q[DEPTH-1]) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign O         = data_q[DEPTH-1];
  assign O_valid   = valid_q[DEPTH-1];
  assign occupancy = occ_q;

`ifndef SYNTHESIS
  if (ASSERT_EN) begin : g_sva
    // Bit k set means the edge k+1 cycles ago was an enabled, unflushed, unreset shift.
    logic [DEPTH-1:0] en_hist_q;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        en_hist_q <= '0;
      end else begin
        en_hist_q <= (en_hist_q << 1) | DEPTH'(shift_en);
      end
    end

    p1_occ_bound: assert property (@(posedge CLK) disable iff (RESET)
      32'(occupancy) <= DEPTH);

    p2_occ_popcount: assert property (@(posedge CLK) disable iff (RESET)
      32'(occupancy) == $countones(valid_q));

    p3_latency: assert property (@(posedge CLK) disable iff (RESET)
      (&en_hist_q && $past(I_valid, DEPTH)) |-> (O_valid && O == $past(I, DEPTH)));

    p4_stall_stable: assert property (@(posedge CLK) disable iff (RESET)
      (!CE && !FLUSH) |=> $stable({O, O_valid, occupancy}));
  end
`endif

endmodule

// File: tb/tb_ff_delay_pipe.sv
// Scoreboard bench for ff_delay_pipe: several builds share one random stimulus stream and each
// is checked against a transaction-level model of accepted items and their due enable counts.
`timescale 1ns/1ps
module tb_ff_delay_pipe;

  localparam int             W      = 8;
  localparam logic [W-1:0]   RV     = 8'hA5;
  localparam int             NCFG   = 4;
  localparam int             K_HOLD = 0;
  localparam int             K_EN   = 1;
  localparam int             K_FL   = 2;
  localparam int             K_RST  = 3;

  function automatic int cfg_depth(input int i);
    case (i)
      0:       return 3;
      1:       return 3;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic bit cfg_gate(input int i);
    return (i == 1 || i == 3);
  endfunction

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fl  = 1'b0;
  logic         ce  = 1'b0;
  logic         iv  = 1'b0;
  logic [W-1:0] din = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic void chk(input string what, input int u, input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %0h expected %0h (t=%0t)", u, what, act, exp, $time);
    end
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int D  = cfg_depth(gi);
    localparam bit G  = cfg_gate(gi);
    localparam int OW = $clog2(D + 1);

    logic [W-1:0]  o;
    logic          ov;
    logic [OW-1:0] occ;

    ff_delay_pipe #(
      .WIDTH(W), .DEPTH(D), .RESET_VALUE(RV), .GATE_DATA(G), .ASSERT_EN(1'b1)
    ) dut (
      .CLK(clk), .RESET(rst), .CE(ce), .FLUSH(fl), .I(din), .I_valid(iv),
      .O(o), .O_valid(ov), .occupancy(occ)
    );

    // Accepted valid items with the enable count after which they sit on O.
    logic [W-1:0] exp_data[$];
    longint       exp_due[$];
    // Raw payload history of enabled edges since reset, newest last.
    logic [W-1:0] dhist[$];
    longint       en_cnt = 0;
    int           kind   = K_RST;

    initial begin : scoreboard
      forever begin
        @(posedge clk);
        if (rst) begin
          kind = K_RST;
          exp_data.delete();
          exp_due.delete();
          dhist.delete();
        end else if (fl) begin
          kind = K_FL;
          exp_data.delete();
          exp_due.delete();
        end else if (ce) begin
          kind = K_EN;
          en_cnt++;
          dhist.push_back(din);
          if (dhist.size() > D) void'(dhist.pop_front());
          if (iv) begin
            exp_data.push_back(din);
            exp_due.push_back(en_cnt + D - 1);
          end
        end else begin
          kind = K_HOLD;
        end
      end
    end

    initial begin : monitor
      logic [W-1:0]  last_out;
      logic [W-1:0]  exp_o;
      logic [W-1:0]  prev_o;
      logic          prev_ov;
      logic [OW-1:0] prev_occ;
      logic          exp_ov;
      last_out = RV;
      prev_o   = RV;
      prev_ov  = 1'b0;
      prev_occ = '0;
      forever begin
        @(posedge clk);
        #1;
        if (kind == K_RST) last_out = RV;
        while (exp_due.size() > 0 && exp_due[0] < en_cnt) begin
          void'(exp_due.pop_front());
          void'(exp_data.pop_front());
        end
        exp_ov = (exp_due.size() > 0) && (exp_due[0] == en_cnt);
        if (exp_ov) last_out = exp_data[0];
        exp_o = G ? last_out : ((dhist.size() == D) ? dhist[0] : RV);

        chk("o_valid", gi, 64'(ov), 64'(exp_ov));
        chk("occupancy", gi, 64'(occ), 64'(exp_due.size()));
        chk("o_data", gi, 64'(o), 64'(exp_o));
        if (kind == K_HOLD) begin
          chk("stall_stable", gi, {o, ov, 32'(occ)}, {prev_o, prev_ov, 32'(prev_occ)});
        end
        prev_o   = o;
        prev_ov  = ov;
        prev_occ = occ;
      end
    end
  end

  task automatic step(input logic r, input logic f, input logic c, input logic v,
                      input logic [W-1:0] d);
    @(negedge clk);
    rst = r;
    fl  = f;
    ce  = c;
    iv  = v;
    din = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 1'b0, W'($urandom));
  endtask

  initial begin : stimulus
    // Reset for two cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    // Back-to-back stream.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
    idle(10);
    // Same stream with a two-cycle stall; the stalled inputs must be ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
    idle(10);
    // Fill then flush with a valid input in the flush cycle.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h44);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h66);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    idle(10);
    // Invalid 0xFF payloads behind a valid 0x11.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    idle(10);
    // Random mix of reset, flush, stall and traffic.
    for (int k = 0; k < 10000; k++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), W'($urandom));
    end
    idle(12);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
